// File: rtl/dds_gen.sv
// ---------------------------------------------------------------------------
// dds_gen : direct digital synthesizer
//
// A phase accumulator advances by 'step' on every enabled clock. Its value is
// mapped to a sine, triangle or square sample selected by WAVETYPE. The sample
// is registered and emitted as unsigned offset binary, one per enabled clock.
//
// Parameters
//   WAVETYPE    "SIN" | "TRI" | "SQU"; any other value gives a constant 0 output
//   ADDR        phase accumulator width, N = 2**ADDR points per period
//   WIDTH       output sample width, ADDR-1 >= WIDTH
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous reset, active-high
//   dds_en       in   1      run enable; low freezes phase and dout
//   phase_start  in   ADDR   initial phase, loaded once after reset
//   step         in   4      phase increment per enabled cycle
//   dout         out  WIDTH  registered waveform sample
// ---------------------------------------------------------------------------
module dds_gen #(
    parameter       WAVETYPE = "SIN",
    parameter int   ADDR     = 10,
    parameter int   WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dds_en,
    input  logic [ADDR-1:0]  phase_start,
    input  logic [3:0]       step,
    output logic [WIDTH-1:0] dout
);

    localparam int N = 2 ** ADDR;
    localparam int H = 2 ** (WIDTH - 1);

    // LOAD: waiting for the first enabled clock to take phase_start.
    // RUN : accumulating and producing samples.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ADDR-1:0]  phase_q, phase_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [WIDTH-1:0] waveVal;

    // Sine sample for phase index p, evaluated only with constant arguments
    // so the table folds away at elaboration. The angle is folded into the
    // first quadrant before a Taylor series, which keeps the series error far
    // below the rounding step of any practical output width.
    function automatic logic [WIDTH-1:0] sinSample(input int p);
        real x;
        real term;
        real s;
        real val;
        int  r;
        bit  neg;
        r   = p % N;
        neg = (r >= N / 2);
        if (neg) r = r - N / 2;
        if (r > N / 4) r = N / 2 - r;
        x    = 2.0 * 3.14159265358979323846 * real'(r) / real'(N);
        s    = 0.0;
        term = x;
        for (int k = 0; k < 12; k++) begin
            s    = s + term;
            term = -term * x * x / real'((2 * k + 2) * (2 * k + 3));
        end
        if (neg) s = -s;
        val = real'(H) + real'(H - 1) * s;
        return WIDTH'($rtoi(val + 0.5));
    endfunction

    // Waveform mapper: purely combinational on the current (pre-update) phase,
    // so the registered output trails the accumulator by one cycle.
    generate
        if (WAVETYPE == "SIN") begin : gSin
            logic [WIDTH-1:0] sinRom [N];
            for (genvar i = 0; i < N; i++) begin : gRom
                assign sinRom[i] = sinSample(i);
            end
            assign waveVal = sinRom[phase_q];
        end else if (WAVETYPE == "TRI") begin : gTri
            // Mirror the lower phase bits in the second half-period, then keep
            // the top WIDTH bits of the folded ramp.
            logic [ADDR-2:0] triRamp;
            assign triRamp = phase_q[ADDR-1] ? ~phase_q[ADDR-2:0] : phase_q[ADDR-2:0];
            assign waveVal = WIDTH'(triRamp >> (ADDR - 1 - WIDTH));
        end else if (WAVETYPE == "SQU") begin : gSqu
            assign waveVal = phase_q[ADDR-1] ? '0 : '1;
        end else begin : gNone
            assign waveVal = '0;
        end
    endgenerate

    // State register; reset forces the load phase back on and clears output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            phase_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic: everything holds while disabled. The load cycle takes
    // phase_start but leaves dout at zero; afterwards phase_start is ignored.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dout_d  = dout_q;
        if (dds_en) begin
            case (state_q)
                ST_LOAD: begin
                    phase_d = phase_start;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    phase_d = phase_q + ADDR'(step);
                    dout_d  = waveVal;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_dds_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_gen : directed bench for dds_gen
//
// Four instances share one set of inputs: sine, triangle, square and an
// unsupported WAVETYPE that must stay at zero. Expected samples come from
// hand-computed constants and small spec-level triangle/square formulas.
// ---------------------------------------------------------------------------
module tb_dds_gen;

    logic       clk;
    logic       reset;
    logic       dds_en;
    logic [9:0] phase_start;
    logic [3:0] step;
    logic [7:0] sinOut;
    logic [7:0] triOut;
    logic [7:0] squOut;
    logic [7:0] badOut;

    int vectors;
    int miscompares;

    dds_gen #(.WAVETYPE("SIN"), .ADDR(10), .WIDTH(8)) uSin (
        .clk(clk), .reset(reset), .dds_en(dds_en),
        .phase_start(phase_start), .step(step), .dout(sinOut)
    );

    dds_gen #(.WAVETYPE("TRI"), .ADDR(10), .WIDTH(8)) uTri (
        .clk(clk), .reset(reset), .dds_en(dds_en),
        .phase_start(phase_start), .step(step), .dout(triOut)
    );

    dds_gen #(.WAVETYPE("SQU"), .ADDR(10), .WIDTH(8)) uSqu (
        .clk(clk), .reset(reset), .dds_en(dds_en),
        .phase_start(phase_start), .step(step), .dout(squOut)
    );

    dds_gen #(.WAVETYPE("XYZ"), .ADDR(10), .WIDTH(8)) uBad (
        .clk(clk), .reset(reset), .dds_en(dds_en),
        .phase_start(phase_start), .step(step), .dout(badOut)
    );

    // 20 ns clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Triangle formula: fold 9-bit ramp in the second half, keep top 8 bits.
    function automatic logic [7:0] triModel(input int p);
        logic [9:0] pv;
        logic [8:0] t;
        pv = 10'(p);
        t  = pv[9] ? ~pv[8:0] : pv[8:0];
        return t[8:1];
    endfunction

    function automatic logic [7:0] squModel(input int p);
        logic [9:0] pv;
        pv = 10'(p);
        return pv[9] ? 8'd0 : 8'd255;
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and consume the load cycle; phase then equals ps.
    task automatic doReset(input int ps, input int st);
        reset       = 1'b1;
        dds_en      = 1'b1;
        phase_start = 10'(ps);
        step        = 4'(st);
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        dds_en      = 1'b1;
        phase_start = 10'd256;
        step        = 4'd1;
        tick();
        tick();
        vectors += 4;
        if (sinOut !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_sin got %0d expected 0", sinOut); end
        if (triOut !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_tri got %0d expected 0", triOut); end
        if (squOut !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_squ got %0d expected 0", squOut); end
        if (badOut !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_bad got %0d expected 0", badOut); end
        reset = 1'b0;
        tick();
        vectors += 3;
        if (sinOut !== 8'd0) begin miscompares++; $display("[TB] FAIL load_sin got %0d expected 0", sinOut); end
        if (triOut !== 8'd0) begin miscompares++; $display("[TB] FAIL load_tri got %0d expected 0", triOut); end
        if (squOut !== 8'd0) begin miscompares++; $display("[TB] FAIL load_squ got %0d expected 0", squOut); end
        tick();
        vectors += 4;
        if (sinOut !== 8'd255) begin miscompares++; $display("[TB] FAIL first_sin got %0d expected 255", sinOut); end
        if (triOut !== 8'd128) begin miscompares++; $display("[TB] FAIL first_tri got %0d expected 128", triOut); end
        if (squOut !== 8'd255) begin miscompares++; $display("[TB] FAIL first_squ got %0d expected 255", squOut); end
        if (badOut !== 8'd0)   begin miscompares++; $display("[TB] FAIL first_bad got %0d expected 0", badOut); end
    endtask

    task automatic test_tri();
        logic [7:0] firstFour [4];
        int p;
        logic [7:0] exp;
        firstFour = '{8'd128, 8'd128, 8'd129, 8'd129};
        doReset(256, 1);
        for (int k = 0; k < 1100; k++) begin
            tick();
            p = (256 + k) % 1024;
            case (k)
                0, 1, 2, 3: exp = firstFour[k];
                255, 256:   exp = 8'd255;
                767, 768:   exp = 8'd0;
                default:    exp = triModel(p);
            endcase
            vectors++;
            if (triOut !== exp) begin
                miscompares++;
                $display("[TB] FAIL tri_run k=%0d phase=%0d got %0d expected %0d", k, p, triOut, exp);
            end
            vectors++;
            if (badOut !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL bad_const k=%0d got %0d expected 0", k, badOut);
            end
        end
    endtask

    task automatic test_sin();
        logic [7:0] exp;
        doReset(384, 2);
        for (int k = 0; k <= 512; k++) begin
            tick();
            case (k)
                0:   exp = 8'd218;
                1:   exp = 8'd217;
                64:  exp = 8'd128;
                192: exp = 8'd1;
                320: exp = 8'd128;
                448: exp = 8'd255;
                512: exp = 8'd218;
                default: exp = 8'd0;
            endcase
            if (k == 0 || k == 1 || k == 64 || k == 192 || k == 320 || k == 448 || k == 512) begin
                vectors++;
                if (sinOut !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL sin_point k=%0d phase=%0d got %0d expected %0d",
                             k, (384 + 2 * k) % 1024, sinOut, exp);
                end
            end
        end
    endtask

    task automatic test_squ();
        int p;
        logic [7:0] exp;
        doReset(512, 4);
        for (int k = 0; k < 300; k++) begin
            tick();
            p   = (512 + 4 * k) % 1024;
            exp = (k < 128) ? 8'd0 : (k < 256) ? 8'd255 : 8'd0;
            vectors++;
            if (squOut !== exp) begin
                miscompares++;
                $display("[TB] FAIL squ_run k=%0d phase=%0d got %0d expected %0d", k, p, squOut, exp);
            end
        end
    endtask

    task automatic test_enable();
        int p;
        doReset(256, 3);
        p = 256;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (triOut !== triModel(p)) begin
                miscompares++;
                $display("[TB] FAIL en_pre k=%0d got %0d expected %0d", k, triOut, triModel(p));
            end
            p = (p + 3) % 1024;
        end
        dds_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors += 2;
            if (triOut !== triModel(p - 3)) begin
                miscompares++;
                $display("[TB] FAIL en_hold_tri k=%0d got %0d expected %0d", k, triOut, triModel(p - 3));
            end
            if (squOut !== 8'd255) begin
                miscompares++;
                $display("[TB] FAIL en_hold_squ k=%0d got %0d expected 255", k, squOut);
            end
        end
        dds_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (triOut !== triModel(p)) begin
                miscompares++;
                $display("[TB] FAIL en_post k=%0d got %0d expected %0d", k, triOut, triModel(p));
            end
            p = (p + 3) % 1024;
        end
    endtask

    task automatic test_step_change();
        int stepSeq [11];
        int p;
        stepSeq = '{1, 1, 1, 1, 5, 5, 5, 0, 0, 0, 0};
        doReset(0, 1);
        phase_start = 10'd700;
        p = 0;
        for (int k = 0; k < 11; k++) begin
            step = 4'(stepSeq[k]);
            tick();
            vectors++;
            if (triOut !== triModel(p)) begin
                miscompares++;
                $display("[TB] FAIL step_seq k=%0d phase=%0d got %0d expected %0d", k, p, triOut, triModel(p));
            end
            p = (p + stepSeq[k]) % 1024;
        end
        vectors++;
        if (triOut !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL step_zero got %0d expected 9", triOut);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] triSeq [4];
        triSeq = '{8'd128, 8'd128, 8'd129, 8'd129};
        doReset(256, 1);
        for (int k = 0; k < 5; k++) tick();
        #5;
        reset = 1'b1;
        #1;
        vectors += 3;
        if (sinOut !== 8'd0) begin miscompares++; $display("[TB] FAIL async_sin got %0d expected 0", sinOut); end
        if (triOut !== 8'd0) begin miscompares++; $display("[TB] FAIL async_tri got %0d expected 0", triOut); end
        if (squOut !== 8'd0) begin miscompares++; $display("[TB] FAIL async_squ got %0d expected 0", squOut); end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (triOut !== 8'd0) begin miscompares++; $display("[TB] FAIL reload_tri got %0d expected 0", triOut); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (triOut !== triSeq[k]) begin
                miscompares++;
                $display("[TB] FAIL rerun_tri k=%0d got %0d expected %0d", k, triOut, triSeq[k]);
            end
            if (k == 0) begin
                vectors++;
                if (sinOut !== 8'd255) begin
                    miscompares++;
                    $display("[TB] FAIL rerun_sin got %0d expected 255", sinOut);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        dds_en      = 1'b0;
        phase_start = '0;
        step        = '0;
        test_reset();
        test_tri();
        test_sin();
        test_squ();
        test_enable();
        test_step_change();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
